// File: rtl/marker_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : marker_scan_ctrl                                             |
// | Description : Frame-level controller for a row stripe marker detector.     |
// |               Tracks vertical runs of per-row detections whose columns     |
// |               stay within COORD_TOL, keeps the lowest-score qualified run  |
// |               of the frame and reports it through a valid/ready handshake. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_in            in   1   pixel clock, rising edge                      |
// |   rst_in            in   1   asynchronous active-high reset                |
// |   pix_valid_in      in   1   current pixel is inside the active area       |
// |   hcount_in         in  11   column of current pixel                       |
// |   vcount_in         in  10   row of current pixel                          |
// |   det_rst_out       out  1   registered reset to the row detector          |
// |   det_done_in       in   1   detector completed a marker in this row       |
// |   det_coord_in      in  11   detector centre column                        |
// |   det_prob_in       in  11   detector not-target score, lower is better    |
// |   result_valid_out  out  1   frame result available                        |
// |   result_ready_in   in   1   consumer accepts result                       |
// |   result_found_out  out  1   a qualified candidate exists                  |
// |   result_x_out      out 11   best candidate column                         |
// |   result_y_out      out 10   best candidate centre row                     |
// |   result_prob_out   out 11   best candidate score (7FF when none)          |
// +----------------------------------------------------------------------------+
module marker_scan_ctrl #(
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768,
  parameter int COORD_TOL = 8,
  parameter int MIN_ROWS  = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pix_valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        det_rst_out,
  input  logic        det_done_in,
  input  logic [10:0] det_coord_in,
  input  logic [10:0] det_prob_in,
  output logic        result_valid_out,
  input  logic        result_ready_in,
  output logic        result_found_out,
  output logic [10:0] result_x_out,
  output logic [9:0]  result_y_out,
  output logic [10:0] result_prob_out
);

  localparam logic [10:0] c_H_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  c_V_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [10:0] c_TOL       = 11'(COORD_TOL);
  localparam logic [3:0]  c_MIN_LEN   = 4'(MIN_ROWS);
  localparam logic [3:0]  c_LEN_MAX   = 4'd15;
  localparam logic [10:0] c_PROB_NONE = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t      state_q;
  logic        det_rst_q;
  logic [3:0]  run_len_q;
  logic [10:0] run_x_q;
  logic [10:0] run_prob_q;
  logic [9:0]  last_row_q;
  logic        upd_pend_q;
  logic        best_found_q;
  logic [10:0] best_x_q;
  logic [9:0]  best_y_q;
  logic [10:0] best_prob_q;
  logic        res_valid_q;
  logic        res_found_q;
  logic [10:0] res_x_q;
  logic [9:0]  res_y_q;
  logic [10:0] res_prob_q;

  logic        best_found_d;
  logic [10:0] best_x_d;
  logic [9:0]  best_y_d;
  logic [10:0] best_prob_d;

  logic        w_row_end;
  logic        w_frame_start;
  logic        w_frame_end;
  logic        w_accept;
  logic        w_extend;
  logic        w_take_best;
  logic [10:0] w_dx;

  assign w_row_end     = pix_valid_in && (hcount_in == c_H_LAST);
  assign w_frame_start = pix_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_frame_end   = w_row_end && (vcount_in == c_V_LAST);

  // run_len_q is never 0 after the first accepted detection of a frame, so
  // "same row as last_row_q" alone identifies a repeated pulse in this row.
  assign w_accept = det_done_in && (state_q == ST_SCAN) && !det_rst_q &&
                    !((run_len_q != 4'd0) && (vcount_in == last_row_q));

  assign w_dx = (det_coord_in >= run_x_q) ? (det_coord_in - run_x_q)
                                          : (run_x_q - det_coord_in);

  // Row adjacency compared at 11 bits so last_row_q = 1023 cannot wrap to 0.
  assign w_extend = (run_len_q != 4'd0) &&
                    ({1'b0, vcount_in} == ({1'b0, last_row_q} + 11'd1)) &&
                    (w_dx <= c_TOL);

  // Evaluated the cycle after a run update, on the registered run state.
  assign w_take_best = upd_pend_q && (run_len_q >= c_MIN_LEN) &&
                       (!best_found_q || (run_prob_q < best_prob_q));

  // Next best is also what gets loaded into the result registers in DRAIN,
  // so an update pending from the final row is never lost.
  always_comb begin
    best_found_d = best_found_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_prob_d  = best_prob_q;
    if (w_take_best) begin
      best_found_d = 1'b1;
      best_x_d     = run_x_q;
      best_y_d     = last_row_q - {7'd0, run_len_q[3:1]};
      best_prob_d  = run_prob_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      det_rst_q    <= 1'b1;
      run_len_q    <= 4'd0;
      run_x_q      <= 11'd0;
      run_prob_q   <= c_PROB_NONE;
      last_row_q   <= 10'd0;
      upd_pend_q   <= 1'b0;
      best_found_q <= 1'b0;
      best_x_q     <= 11'd0;
      best_y_q     <= 10'd0;
      best_prob_q  <= c_PROB_NONE;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_x_q      <= 11'd0;
      res_y_q      <= 10'd0;
      res_prob_q   <= c_PROB_NONE;
    end else begin
      upd_pend_q   <= 1'b0;
      best_found_q <= best_found_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_prob_q  <= best_prob_d;

      case (state_q)
        ST_IDLE: begin
          det_rst_q <= 1'b1;
          if (w_frame_start) begin
            state_q      <= ST_SCAN;
            det_rst_q    <= 1'b0;
            run_len_q    <= 4'd0;
            run_x_q      <= 11'd0;
            run_prob_q   <= c_PROB_NONE;
            last_row_q   <= 10'd0;
            best_found_q <= 1'b0;
            best_x_q     <= 11'd0;
            best_y_q     <= 10'd0;
            best_prob_q  <= c_PROB_NONE;
          end
        end

        ST_SCAN: begin
          if (w_accept) begin
            upd_pend_q <= 1'b1;
            last_row_q <= vcount_in;
            run_x_q    <= det_coord_in;
            if (w_extend) begin
              if (run_len_q != c_LEN_MAX) begin
                run_len_q <= run_len_q + 4'd1;
              end
              if (det_prob_in < run_prob_q) begin
                run_prob_q <= det_prob_in;
              end
            end else begin
              run_len_q  <= 4'd1;
              run_prob_q <= det_prob_in;
            end
          end
          if (w_frame_end) begin
            state_q   <= ST_DRAIN;
            det_rst_q <= 1'b1;
          end else begin
            // One-cycle detector reset between rows.
            det_rst_q <= w_row_end;
          end
        end

        ST_DRAIN: begin
          det_rst_q   <= 1'b1;
          state_q     <= ST_REPORT;
          res_valid_q <= 1'b1;
          res_found_q <= best_found_d;
          res_x_q     <= best_x_d;
          res_y_q     <= best_y_d;
          res_prob_q  <= best_prob_d;
        end

        ST_REPORT: begin
          det_rst_q <= 1'b1;
          if (result_ready_in) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            res_x_q     <= 11'd0;
            res_y_q     <= 10'd0;
            res_prob_q  <= c_PROB_NONE;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          det_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign det_rst_out      = det_rst_q;
  assign result_valid_out = res_valid_q;
  assign result_found_out = res_found_q;
  assign result_x_out     = res_x_q;
  assign result_y_out     = res_y_q;
  assign result_prob_out  = res_prob_q;

endmodule
`default_nettype wire

// File: tb/tb_marker_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_marker_scan_ctrl                                          |
// | Description : Self-checking bench for marker_scan_ctrl. Streams whole      |
// |               frames with detector pulses taken from a scenario table;     |
// |               expected frame results go into a scoreboard queue and are    |
// |               compared when the DUT hands a result over.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_marker_scan_ctrl;

  localparam int H = 8;
  localparam int V = 256;
  localparam int N_SCEN = 11;

  logic        clk_in;
  logic        rst_in;
  logic        pix_valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        det_rst_out;
  logic        det_done_in;
  logic [10:0] det_coord_in;
  logic [10:0] det_prob_in;
  logic        result_valid_out;
  logic        result_ready_in;
  logic        result_found_out;
  logic [10:0] result_x_out;
  logic [9:0]  result_y_out;
  logic [10:0] result_prob_out;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  marker_scan_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .COORD_TOL(8),
    .MIN_ROWS (3)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .pix_valid_in    (pix_valid_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .det_rst_out     (det_rst_out),
    .det_done_in     (det_done_in),
    .det_coord_in    (det_coord_in),
    .det_prob_in     (det_prob_in),
    .result_valid_out(result_valid_out),
    .result_ready_in (result_ready_in),
    .result_found_out(result_found_out),
    .result_x_out    (result_x_out),
    .result_y_out    (result_y_out),
    .result_prob_out (result_prob_out)
  );

  typedef struct {
    int scen;
    int row;
    int col;
    int x;
    int prob;
  } det_t;

  typedef struct {
    logic        found;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] prob;
  } res_t;

  det_t dets[$];
  res_t exps[N_SCEN];
  res_t sb_q[$];
  res_t mon_e;
  res_t snap;

  int n_checks = 0;
  int n_fail   = 0;
  int n_hs     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic add_det(input int s, input int r, input int c, input int x, input int p);
    det_t d;
    d.scen = s; d.row = r; d.col = c; d.x = x; d.prob = p;
    dets.push_back(d);
  endtask

  task automatic set_exp(input int s, input logic f, input int x, input int y, input int p);
    exps[s].found = f;
    exps[s].x     = 11'(x);
    exps[s].y     = 10'(y);
    exps[s].prob  = 11'(p);
  endtask

  // Handshake monitor: every accepted result must match the oldest expectation.
  always @(negedge clk_in) begin
    if (!rst_in && result_valid_out && result_ready_in) begin
      n_hs++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: actual=result x=%0d y=%0d required=none", result_x_out, result_y_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_found", 64'(result_found_out), 64'(mon_e.found));
        check("result_x",     64'(result_x_out),     64'(mon_e.x));
        check("result_y",     64'(result_y_out),     64'(mon_e.y));
        check("result_prob",  64'(result_prob_out),  64'(mon_e.prob));
      end
    end
  end

  // Streams nrows rows of scenario scen. Called and returning at 1 ns past a
  // rising edge. With live set, the DUT is expected to own this frame.
  task automatic drive_frame(input int scen, input int nrows, input bit live);
    for (int v = 0; v < nrows; v++) begin
      for (int h = 0; h < H; h++) begin
        pix_valid_in = 1'b1;
        hcount_in    = 11'(h);
        vcount_in    = 10'(v);
        det_done_in  = 1'b0;
        det_coord_in = 11'd0;
        det_prob_in  = 11'd0;
        foreach (dets[k]) begin
          if (dets[k].scen == scen && dets[k].row == v && dets[k].col == h) begin
            det_done_in  = 1'b1;
            det_coord_in = 11'(dets[k].x);
            det_prob_in  = 11'(dets[k].prob);
          end
        end
        if (live && h <= 1) begin
          check("det_rst_out", 64'(det_rst_out), (h == 0) ? 64'd1 : 64'd0);
          check("valid_low_during_scan", 64'(result_valid_out), 64'd0);
        end
        @(posedge clk_in); #1;
      end
    end
    pix_valid_in = 1'b0;
    det_done_in  = 1'b0;
    hcount_in    = 11'd0;
    vcount_in    = 10'd0;
  endtask

  task automatic wait_hs(input int budget);
    int start;
    start = n_hs;
    for (int i = 0; i < budget && n_hs == start; i++) begin
      @(posedge clk_in); #1;
    end
    check("handshake_seen", 64'(n_hs != start), 64'd1);
    repeat (2) begin @(posedge clk_in); #1; end
    check("valid_after_hs", 64'(result_valid_out), 64'd0);
    check("prob_after_hs",  64'(result_prob_out),  64'h7FF);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !result_valid_out; i++) begin
      @(posedge clk_in); #1;
    end
    check("valid_rise", 64'(result_valid_out), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  initial begin
    // ---------------- scenario table ----------------
    add_det(0, 100, 2, 500, 9); add_det(0, 101, 2, 500, 4); add_det(0, 102, 2, 500, 7);
    set_exp(0, 1'b1, 500, 101, 4);
    add_det(1, 100, 2, 500, 9); add_det(1, 101, 2, 500, 4);
    set_exp(1, 1'b0, 0, 0, 11'h7FF);
    add_det(2, 200, 2, 300, 10); add_det(2, 201, 2, 300, 10); add_det(2, 202, 2, 300, 10);
    add_det(2, 203, 2, 310, 2);
    set_exp(2, 1'b1, 300, 201, 10);
    add_det(3, 50, 2, 100, 20); add_det(3, 51, 2, 108, 21); add_det(3, 52, 2, 100, 22);
    set_exp(3, 1'b1, 100, 51, 20);
    for (int r = 10; r <= 12; r++) add_det(4, r, 2, 200, 6);
    for (int r = 40; r <= 42; r++) add_det(4, r, 2, 600, 6);
    set_exp(4, 1'b1, 200, 11, 6);
    for (int r = 10; r <= 12; r++) add_det(5, r, 2, 200, 6);
    for (int r = 40; r <= 42; r++) add_det(5, r, 2, 600, 5);
    set_exp(5, 1'b1, 600, 41, 5);
    add_det(6, 10, 2, 50, 1); add_det(6, 11, 2, 50, 1);
    add_det(6, 13, 2, 50, 9); add_det(6, 14, 2, 50, 9); add_det(6, 15, 2, 50, 9);
    set_exp(6, 1'b1, 50, 14, 9);
    add_det(7, 149, 2, 400, 9); add_det(7, 150, 2, 400, 9); add_det(7, 150, 5, 900, 0);
    add_det(7, 151, 2, 400, 9);
    set_exp(7, 1'b1, 400, 150, 9);
    for (int r = 1; r <= 17; r++) add_det(8, r, 2, 50, 30);
    add_det(8, 18, 2, 50, 5);
    set_exp(8, 1'b1, 50, 11, 5);
    add_det(9, 253, 7, 700, 3); add_det(9, 254, 7, 700, 3); add_det(9, 255, 7, 700, 3);
    set_exp(9, 1'b1, 700, 254, 3);
    add_det(10, 60, 2, 100, 4); add_det(10, 61, 0, 100, 4); add_det(10, 62, 2, 100, 4);
    set_exp(10, 1'b0, 0, 0, 11'h7FF);

    // ---------------- reset state ----------------
    rst_in          = 1'b0;
    pix_valid_in    = 1'b0;
    hcount_in       = 11'd0;
    vcount_in       = 10'd0;
    det_done_in     = 1'b0;
    det_coord_in    = 11'd0;
    det_prob_in     = 11'd0;
    result_ready_in = 1'b1;
    #1 rst_in = 1'b1;
    #1;
    check("rst_det_rst", 64'(det_rst_out),      64'd1);
    check("rst_valid",   64'(result_valid_out), 64'd0);
    check("rst_found",   64'(result_found_out), 64'd0);
    check("rst_x",       64'(result_x_out),     64'd0);
    check("rst_y",       64'(result_y_out),     64'd0);
    check("rst_prob",    64'(result_prob_out),  64'h7FF);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle_cycles(2);

    // ---------------- table-driven frames ----------------
    for (int s = 0; s < N_SCEN; s++) begin
      sb_q.push_back(exps[s]);
      drive_frame(s, V, 1'b1);
      wait_hs(20);
    end

    // ---------------- stalled consumer while next frame starts ----------------
    begin
      int hs_before;
      result_ready_in = 1'b0;
      sb_q.push_back(exps[0]);
      drive_frame(0, V, 1'b1);
      wait_valid(20);
      snap.found = result_found_out;
      snap.x     = result_x_out;
      snap.y     = result_y_out;
      snap.prob  = result_prob_out;
      hs_before  = n_hs;
      fork
        drive_frame(5, V, 1'b0);
        begin
          repeat (50) begin
            @(negedge clk_in);
            check("hold_valid", 64'(result_valid_out), 64'd1);
            check("hold_outputs", {31'd0, result_found_out, result_x_out, result_y_out, result_prob_out},
                                  {31'd0, snap.found, snap.x, snap.y, snap.prob});
          end
          @(posedge clk_in); #1;
          result_ready_in = 1'b1;
        end
      join
      check("one_hs_in_skipped_frame", 64'(n_hs - hs_before), 64'd1);
      idle_cycles(10);
      check("no_result_for_skipped", 64'(result_valid_out), 64'd0);
      sb_q.push_back(exps[6]);
      drive_frame(6, V, 1'b1);
      wait_hs(20);
    end

    // ---------------- reset in the middle of a scan ----------------
    drive_frame(0, 120, 1'b1);
    pix_valid_in = 1'b1; hcount_in = 11'd0; vcount_in = 10'd120;
    @(posedge clk_in); #1;
    hcount_in = 11'd1;
    @(posedge clk_in); #1;
    check("det_rst_mid_row", 64'(det_rst_out), 64'd0);
    rst_in = 1'b1;
    #1;
    check("async_rst_det_rst", 64'(det_rst_out), 64'd1);
    check("async_rst_valid",   64'(result_valid_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    pix_valid_in = 1'b0;
    hcount_in = 11'd0; vcount_in = 10'd0;
    idle_cycles(30);
    check("no_result_after_scan_rst", 64'(result_valid_out), 64'd0);
    sb_q.push_back(exps[5]);
    drive_frame(5, V, 1'b1);
    wait_hs(20);

    // ---------------- reset while reporting ----------------
    result_ready_in = 1'b0;
    drive_frame(0, V, 1'b1);
    wait_valid(20);
    rst_in = 1'b1;
    #1;
    check("report_rst_valid", 64'(result_valid_out), 64'd0);
    check("report_rst_found", 64'(result_found_out), 64'd0);
    check("report_rst_x",     64'(result_x_out),     64'd0);
    check("report_rst_prob",  64'(result_prob_out),  64'h7FF);
    check("report_rst_detrst", 64'(det_rst_out),     64'd1);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    result_ready_in = 1'b1;
    idle_cycles(30);
    check("no_result_after_report_rst", 64'(result_valid_out), 64'd0);
    sb_q.push_back(exps[1]);
    drive_frame(1, V, 1'b1);
    wait_hs(20);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/marker_scan_ctrl.md
MARKER_SCAN_CTRL -- requirements
Module: marker_scan_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 1024: active pixels per row.
REQ-002 Parameter V_ACTIVE, default 768: active rows per frame.
REQ-003 Parameter COORD_TOL, default 8: maximum |Δx| between detections on consecutive rows of one run.
REQ-004 Parameter MIN_ROWS, default 3: run length that qualifies a candidate.
REQ-005 clk_in  in  1  pixel clock; all logic on its rising edge.
REQ-006 rst_in  in  1  reset, asynchronous, active-high.
REQ-007 pix_valid_in  in  1  current pixel is in the active area.
REQ-008 hcount_in  in  11  column of current pixel.
REQ-009 vcount_in  in  10  row of current pixel.
REQ-010 det_rst_out  out  1  active-high reset to the row stripe detector.
REQ-011 det_done_in  in  1  one-cycle pulse: detector completed a marker in this row.
REQ-012 det_coord_in  in  11  detector centre column, valid with det_done_in.
REQ-013 det_prob_in  in  11  detector not-target score (lower is better), valid with det_done_in.
REQ-014 result_valid_out  out  1  frame result available.
REQ-015 result_ready_in  in  1  consumer accepts result.
REQ-016 result_found_out  out  1  a qualified candidate exists.
REQ-017 result_x_out  out  11  best candidate column.
REQ-018 result_y_out  out  10  best candidate centre row.
REQ-019 result_prob_out  out  11  best candidate score.

Function
REQ-020 FSM states IDLE, SCAN, DRAIN, REPORT; reset state IDLE.
REQ-021 IDLE->SCAN when pix_valid_in && hcount_in==0 && vcount_in==0; run and best trackers cleared on this transition.
REQ-022 SCAN->DRAIN on the cycle after pix_valid_in && hcount_in==H_ACTIVE-1 && vcount_in==V_ACTIVE-1; DRAIN->REPORT after exactly one cycle.
REQ-023 REPORT: result_valid_out=1; all result_* outputs held stable until result_valid_out && result_ready_in, then REPORT->IDLE next cycle.
REQ-024 Frames starting while not in IDLE are skipped entirely; no partial-frame results.
REQ-025 det_rst_out registered; =1 in every state except SCAN; in SCAN =1 for exactly one cycle following a sampled pixel with pix_valid_in && hcount_in==H_ACTIVE-1, else 0.
REQ-026 det_done_in ignored outside SCAN, during cycles with det_rst_out=1, and for any second or later pulse within the same vcount_in row.
REQ-027 Accepted detection, run extension when run_len!=0 && vcount_in==last_row+1 && |det_coord_in-run_x|<=COORD_TOL: run_len+1 saturating at 15, run_x<=det_coord_in, run_prob<=min(run_prob, det_prob_in).
REQ-028 Otherwise new run: run_len<=1, run_x<=det_coord_in, run_prob<=det_prob_in; in both cases last_row<=vcount_in.
REQ-029 |Δx| computed as unsigned absolute difference at 11 bits; no wrap.
REQ-030 Best update one cycle after a run update: if run_len>=MIN_ROWS && (no best || run_prob<best_prob), best_x<=run_x, best_y<=last_row-(run_len>>1), best_prob<=run_prob, found<=1.
REQ-031 Ties (run_prob==best_prob) keep existing best.
REQ-032 DRAIN guarantees a best update pending from the final row is applied before REPORT.
REQ-033 No best at frame end: result_found_out=0, result_x_out=0, result_y_out=0, result_prob_out=11'h7FF.
REQ-034 result_* outputs are 0 (result_prob_out=11'h7FF) whenever state!=REPORT.

Reset
REQ-035 rst_in asserted: state=IDLE, det_rst_out=1, result_valid_out=0, result_found_out=0, result_x_out=0, result_y_out=0, result_prob_out=11'h7FF, run_len=0, last_row=0, best cleared, immediately and asynchronously.
REQ-036 Reset mid-SCAN or mid-REPORT discards the frame; result_valid_out falls without handshake; next result comes from the next complete frame.

Verification
REQ-037 Done at x=500 on rows 100,101,102 with prob 9,4,7, ready=1 -> one result: found=1, x=500, y=101, prob=4.
REQ-038 Done on rows 100,101 only (MIN_ROWS=3) -> result found=0, x=0, y=0, prob=7FF.
REQ-039 Rows 200-202 x=300 then x=310 on 203 (tol 8) -> run restarts at 203; best x=300, y=201.
REQ-040 Two qualified runs, probs 6 then 6 -> first run reported (tie rule); second run prob 5 -> second reported.
REQ-041 ready=0 for 50 cycles in REPORT while next frame starts -> outputs stable, valid held; that frame skipped; after handshake IDLE waits for following frame.
REQ-042 Two done pulses on row 150 and rst_in pulse mid-frame -> second pulse ignored; reset drops valid, det_rst_out=1, no result until next full frame.
